// File: rtl/alu_issue_unit.sv
// Issue stage for the integer ALU: decodes one RV32 R/I-type op, drives the ALU for
// a single cycle, then holds the captured result for writeback until it is accepted.
module alu_issue_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_instr,
    input  logic [N-1:0] in_rs1_val,
    input  logic [N-1:0] in_rs2_val,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_op,
    input  logic [N-1:0] alu_y,
    input  logic         alu_zero,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic         out_zero,
    output logic [4:0]   out_rd,
    output logic         out_illegal
);

    localparam logic [3:0] OP_AND = 4'b0001, OP_OR  = 4'b0010, OP_SLL = 4'b0011,
                           OP_ADD = 4'b0100, OP_XOR = 4'b0111, OP_SUB = 4'b1001,
                           OP_SRL = 4'b1010, OP_SLT = 4'b1100, OP_MUL = 4'b1110;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t       state_q;
    logic [N-1:0] alu_a_q, alu_b_q, out_result_q;
    logic [3:0]   alu_op_q;
    logic         out_zero_q, out_illegal_q;
    logic [4:0]   out_rd_q;

    logic [6:0]   opcode, funct7;
    logic [2:0]   funct3;
    logic         dec_legal;
    logic [3:0]   dec_op;
    logic [N-1:0] dec_b_raw, dec_b;
    logic         unused_rs1_field;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    // The rs1 index field is consumed upstream; only its value arrives here.
    assign unused_rs1_field = ^in_instr[19:15];

    always_comb begin
        dec_legal = 1'b0;
        dec_op    = 4'b0000;
        dec_b_raw = in_rs2_val;
        if (opcode == 7'b0110011) begin
            dec_b_raw = in_rs2_val;
            unique case ({funct7, funct3})
                {7'b0000000, 3'b000}: begin dec_legal = 1'b1; dec_op = OP_ADD; end
                {7'b0000000, 3'b111}: begin dec_legal = 1'b1; dec_op = OP_AND; end
                {7'b0000000, 3'b110}: begin dec_legal = 1'b1; dec_op = OP_OR;  end
                {7'b0000000, 3'b100}: begin dec_legal = 1'b1; dec_op = OP_XOR; end
                {7'b0000000, 3'b010}: begin dec_legal = 1'b1; dec_op = OP_SLT; end
                {7'b0000000, 3'b001}: begin dec_legal = 1'b1; dec_op = OP_SLL; end
                {7'b0000000, 3'b101}: begin dec_legal = 1'b1; dec_op = OP_SRL; end
                {7'b0100000, 3'b000}: begin dec_legal = 1'b1; dec_op = OP_SUB; end
                {7'b0000001, 3'b000}: begin dec_legal = 1'b1; dec_op = OP_MUL; end
                default: ;
            endcase
        end else if (opcode == 7'b0010011) begin
            dec_b_raw = {{(N-12){in_instr[31]}}, in_instr[31:20]};
            unique case (funct3)
                3'b000: begin dec_legal = 1'b1; dec_op = OP_ADD; end
                3'b111: begin dec_legal = 1'b1; dec_op = OP_AND; end
                3'b110: begin dec_legal = 1'b1; dec_op = OP_OR;  end
                3'b100: begin dec_legal = 1'b1; dec_op = OP_XOR; end
                3'b010: begin dec_legal = 1'b1; dec_op = OP_SLT; end
                3'b001: begin dec_legal = (funct7 == 7'b0000000); dec_op = OP_SLL; end
                3'b101: begin dec_legal = (funct7 == 7'b0000000); dec_op = OP_SRL; end
                default: ;
            endcase
            if (!dec_legal) dec_op = 4'b0000;
        end
    end

    // Shift amount is confined to 5 bits so the ALU never sees an oversized shift.
    assign dec_b = (dec_op == OP_SLL || dec_op == OP_SRL) ?
                   {{(N-5){1'b0}}, dec_b_raw[4:0]} : dec_b_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= 4'b0000;
            out_result_q  <= '0;
            out_zero_q    <= 1'b0;
            out_rd_q      <= 5'd0;
            out_illegal_q <= 1'b0;
        end else if (flush) begin
            state_q       <= IDLE;
            alu_op_q      <= 4'b0000;
            out_illegal_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (in_valid) begin
                    out_rd_q <= in_instr[11:7];
                    if (dec_legal) begin
                        alu_a_q  <= in_rs1_val;
                        alu_b_q  <= dec_b;
                        alu_op_q <= dec_op;
                        state_q  <= EXEC;
                    end else begin
                        out_illegal_q <= 1'b1;
                        out_result_q  <= '0;
                        out_zero_q    <= 1'b0;
                        state_q       <= RESP;
                    end
                end
                EXEC: begin
                    out_result_q  <= alu_y;
                    out_zero_q    <= alu_zero;
                    out_illegal_q <= 1'b0;
                    alu_op_q      <= 4'b0000;
                    state_q       <= RESP;
                end
                RESP: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == RESP);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign out_result  = out_result_q;
    assign out_zero    = out_zero_q;
    assign out_rd      = out_rd_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed and randomized checks of alu_issue_unit against a mnemonic-level reference
// model; the bench also plays the role of the combinational ALU.
module tb_alu_issue_unit;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_instr = '0, in_rs1_val = '0, in_rs2_val = '0;
    logic        in_ready, out_valid, out_zero, out_illegal, alu_zero;
    logic [31:0] alu_a, alu_b, alu_y, out_result;
    logic [3:0]  alu_op;
    logic [4:0]  out_rd;

    int errors = 0, checks = 0;

    alu_issue_unit #(.N(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_rd(out_rd), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // Integer ALU as seen by the issue unit
    always_comb begin
        alu_y = 32'd0;
        case (alu_op)
            4'b0100: alu_y = alu_a + alu_b;
            4'b1001: alu_y = alu_a - alu_b;
            4'b0001: alu_y = alu_a & alu_b;
            4'b0010: alu_y = alu_a | alu_b;
            4'b0111: alu_y = alu_a ^ alu_b;
            4'b1100: alu_y = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            4'b0011: alu_y = alu_a << alu_b[4:0];
            4'b1010: alu_y = alu_a >> alu_b[4:0];
            4'b1110: alu_y = alu_a * alu_b;
            default: alu_y = 32'd0;
        endcase
        alu_zero = (alu_y == 32'd0);
    end

    typedef enum {M_ILL, M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLT, M_SLL, M_SRL, M_MUL} mn_t;

    function automatic void model(input logic [31:0] ins, r1, r2, output bit legal,
                                  output logic [3:0] op, output logic [31:0] b,
                                  output logic [31:0] res);
        mn_t m = M_ILL;
        logic [6:0] opc = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        b = 32'd0;
        if (opc == 7'h33) begin
            b = r2;
            if (f7 == 7'h00) begin
                case (f3)
                    3'd0: m = M_ADD; 3'd7: m = M_AND; 3'd6: m = M_OR; 3'd4: m = M_XOR;
                    3'd2: m = M_SLT; 3'd1: m = M_SLL; 3'd5: m = M_SRL; default: m = M_ILL;
                endcase
            end else if (f7 == 7'h20 && f3 == 3'd0) m = M_SUB;
            else if (f7 == 7'h01 && f3 == 3'd0) m = M_MUL;
        end else if (opc == 7'h13) begin
            b = {{20{ins[31]}}, ins[31:20]};
            case (f3)
                3'd0: m = M_ADD; 3'd7: m = M_AND; 3'd6: m = M_OR; 3'd4: m = M_XOR;
                3'd2: m = M_SLT;
                3'd1: m = (f7 == 7'h00) ? M_SLL : M_ILL;
                3'd5: m = (f7 == 7'h00) ? M_SRL : M_ILL;
                default: m = M_ILL;
            endcase
        end
        if (m == M_SLL || m == M_SRL) b = b % 32;
        legal = (m != M_ILL);
        op = 4'b0000; res = 32'd0;
        case (m)
            M_ADD: begin op = 4'b0100; res = r1 + b; end
            M_SUB: begin op = 4'b1001; res = r1 - b; end
            M_AND: begin op = 4'b0001; res = r1 & b; end
            M_OR:  begin op = 4'b0010; res = r1 | b; end
            M_XOR: begin op = 4'b0111; res = r1 ^ b; end
            M_SLT: begin op = 4'b1100; res = (int'(r1) < int'(b)) ? 32'd1 : 32'd0; end
            M_SLL: begin op = 4'b0011; res = r1 * (32'd1 << b); end
            M_SRL: begin op = 4'b1010; res = r1 / (64'd1 << b); end
            M_MUL: begin op = 4'b1110; res = 32'((64'(r1) * 64'(b)) & 64'hFFFF_FFFF); end
            default: ;
        endcase
        if (!legal) b = 32'd0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered and left at posedge+1 with the DUT idle.
    task automatic do_op(input logic [31:0] ins, r1, r2, input int hold, input bit flush_resp);
        bit legal;
        logic [3:0] eop;
        logic [31:0] eb, eres;
        model(ins, r1, r2, legal, eop, eb, eres);
        in_instr = ins; in_rs1_val = r1; in_rs2_val = r2; in_valid = 1'b1;
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_instr = $urandom; in_rs1_val = $urandom; in_rs2_val = $urandom;
        if (legal) begin
            @(negedge clk);
            check("exec_op", alu_op, eop);
            check("exec_a", alu_a, r1);
            check("exec_b", alu_b, eb);
            check("exec_no_valid", out_valid, 0);
            check("exec_no_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("resp_valid", out_valid, 1);
        check("resp_result", out_result, eres);
        check("resp_zero", out_zero, legal ? (eres == 0) : 0);
        check("resp_rd", out_rd, ins[11:7]);
        check("resp_illegal", out_illegal, !legal);
        check("resp_op_idle", alu_op, 0);
        check("resp_no_ready", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; in_instr = 32'h002081B3;
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_result", out_result, eres);
            check("hold_rd", out_rd, ins[11:7]);
            check("hold_illegal", out_illegal, !legal);
            check("hold_no_ready", in_ready, 0);
        end
        if (flush_resp) begin
            flush = 1'b1; out_ready = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0; out_ready = 1'b0;
            @(negedge clk);
            check("flush_valid", out_valid, 0);
            check("flush_illegal", out_illegal, 0);
            check("flush_op", alu_op, 0);
        end else begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            @(negedge clk);
            check("done_valid", out_valid, 0);
        end
        check("done_ready", in_ready, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ins, r1, r2;
        // Reset values
        #3;
        check("rst_valid", out_valid, 0);
        check("rst_a", alu_a, 0);
        check("rst_b", alu_b, 0);
        check("rst_op", alu_op, 0);
        check("rst_result", out_result, 0);
        check("rst_zero", out_zero, 0);
        check("rst_rd", out_rd, 0);
        check("rst_illegal", out_illegal, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed ops from the plan
        do_op(32'h002081B3, 32'd5, 32'd7, 0, 0);              // add
        do_op(32'h402081B3, 32'h1234, 32'h1234, 1, 0);       // sub -> zero
        do_op(32'hFFF00093, 32'd0, 32'h55, 0, 0);            // addi x1,x0,-1
        do_op(32'h002091B3, 32'd1, 32'h21, 0, 0);            // sll, amount masked to 1
        do_op(32'h4020D1B3, 32'd9, 32'd2, 0, 0);             // sra -> illegal
        do_op(32'h0020A1B3, 32'hFFFF_FFFF, 32'd1, 0, 0);     // slt -1 < 1
        do_op(32'h40209193, 32'h80, 32'd0, 0, 0);            // slli with funct7!=0 -> illegal
        do_op(32'h0030D193, 32'h80, 32'd0, 0, 0);            // srli 3
        do_op(32'h002081B3, 32'd10, 32'd20, 4, 0);           // back-pressure for 4 cycles

        // Reset in the middle of EXEC: outputs clear at once, nothing emitted afterwards
        in_instr = 32'h002081B3; in_rs1_val = 32'd3; in_rs2_val = 32'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_op", alu_op, 0);
        check("mid_rst_a", alu_a, 0);
        check("mid_rst_b", alu_b, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_result", out_result, 0);
        check("mid_rst_rd", out_rd, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_no_valid", out_valid, 0);
            check("post_rst_ready", in_ready, 1);
        end
        @(posedge clk); #1;
        do_op(32'h002081B3, 32'd5, 32'd7, 0, 0);

        // Flush in RESP, legal and illegal
        do_op(32'h002081B3, 32'd1, 32'd2, 2, 1);
        do_op(32'h0000B1B3, 32'd1, 32'd2, 1, 1);             // funct3 011 -> illegal

        // Flush during EXEC drops the op
        in_instr = 32'h002081B3; in_rs1_val = 32'd6; in_rs2_val = 32'd6; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_exec_op", alu_op, 0);
        check("flush_exec_valid", out_valid, 0);
        check("flush_exec_ready", in_ready, 1);

        // Flush wins over in_valid in IDLE
        @(posedge clk); #1;
        in_instr = 32'h002081B3; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_idle_ready", in_ready, 1);
        check("flush_idle_op", alu_op, 0);
        @(negedge clk);
        check("flush_idle_valid", out_valid, 0);
        @(posedge clk); #1;
        do_op(32'h402081B3, 32'd50, 32'd8, 0, 0);

        // Randomized ops
        for (int n = 0; n < 150; n++) begin
            ins = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: ins[6:0] = 7'h33;
                5, 6, 7, 8:    ins[6:0] = 7'h13;
                default:       ins[6:0] = 7'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0, 1: ins[31:25] = 7'h00;
                2:    ins[31:25] = 7'h20;
                3:    ins[31:25] = 7'h01;
                default: ;
            endcase
            r1 = $urandom;
            r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
            do_op(ins, r1, r2, $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
